// File: rtl/wb_gpio_master.sv
`default_nettype none
// ============================================================================
// wb_gpio_master : Wishbone initiator that mirrors the switch register into the LED register
// Optional: SW_DEBOUNCE_EN (write only after DEB_COUNT identical reads). Rev 1.0
// ============================================================================
module wb_gpio_master #(
   parameter int PERIOD    = 1000,
   parameter int TIMEOUT   = 16,
   parameter int DEB_COUNT = 4
) (
   input  logic        wb_clk_i,
   input  logic        wb_rst_i,
   output logic        wb_adr_o,
   output logic [15:0] wb_dat_o,
   input  logic [15:0] wb_dat_i,
   output logic [1:0]  wb_sel_o,
   output logic        wb_we_o,
   output logic        wb_stb_o,
   output logic        wb_cyc_o,
   input  logic        wb_ack_i,
   input  logic        enable_i,
   input  logic        force_i,
   input  logic        clear_i,
   output logic [7:0]  sw_val_o,
   output logic        busy_o,
   output logic        timeout_o,
   output logic [7:0]  err_cnt_o
);

   localparam int PW = (PERIOD > 1) ? $clog2(PERIOD) : 1;
   localparam int TW = (TIMEOUT > 1) ? $clog2(TIMEOUT + 1) : 1;

   typedef enum logic [1:0] {
      S_IDLE = 2'd0,
      S_RD   = 2'd1,
      S_WR   = 2'd2
   } state_t;

   state_t        state_q, state_d;
   logic [PW-1:0] poll_q, poll_d;
   logic [TW-1:0] tmo_q, tmo_d;
   logic [7:0]    sw_val_q, sw_val_d;
   logic [7:0]    led_q, led_d;
   logic          force_q, force_d;
   logic          timeout_q, timeout_d;
   logic [7:0]    err_q, err_d;
   logic          cyc_q, cyc_d;
   logic          we_q, we_d;
   logic          adr_q, adr_d;
   logic [1:0]    sel_q, sel_d;
   logic [15:0]   dat_q, dat_d;

   logic [7:0]    rd_val;
   logic          wr_cond;
   logic          abort;
   logic          force_clr;

   // Upper read byte carries nothing for this slave.
   logic unused_dat_hi;
   assign unused_dat_hi = ^wb_dat_i[15:8];
   assign rd_val        = wb_dat_i[7:0];

`ifdef SW_DEBOUNCE_EN
   localparam int DW = $clog2(DEB_COUNT + 1);
   logic [DW-1:0] deb_q, deb_d;

   always_comb begin
      deb_d = deb_q;
      if (state_q == S_RD && wb_ack_i) begin
         if (rd_val == sw_val_q)
            deb_d = (deb_q >= DW'(DEB_COUNT)) ? deb_q : deb_q + DW'(1);
         else
            deb_d = DW'(1);
      end
   end

   assign wr_cond = (deb_d >= DW'(DEB_COUNT)) && ((rd_val != led_q) || force_q);

   always_ff @(posedge wb_clk_i) begin
      if (wb_rst_i) deb_q <= '0;
      else          deb_q <= deb_d;
   end
`else
   localparam logic unused_deb_param = (DEB_COUNT > 0);
   assign wr_cond = (rd_val != led_q) || force_q;
`endif

   always_comb begin
      state_d   = state_q;
      poll_d    = poll_q;
      tmo_d     = tmo_q;
      sw_val_d  = sw_val_q;
      led_d     = led_q;
      timeout_d = timeout_q;
      err_d     = err_q;
      abort     = 1'b0;
      force_clr = 1'b0;

      case (state_q)
         S_IDLE: begin
            if (enable_i) begin
               if (poll_q == '0) begin
                  poll_d  = PW'(PERIOD - 1);
                  tmo_d   = '0;
                  state_d = S_RD;
               end else begin
                  poll_d = poll_q - PW'(1);
               end
            end
         end
         S_RD: begin
            if (wb_ack_i) begin
               sw_val_d = rd_val;
               tmo_d    = '0;
               state_d  = wr_cond ? S_WR : S_IDLE;
            end else if (tmo_q == TW'(TIMEOUT - 1)) begin
               abort   = 1'b1;
               state_d = S_IDLE;
            end else begin
               tmo_d = tmo_q + TW'(1);
            end
         end
         S_WR: begin
            if (wb_ack_i) begin
               led_d     = sw_val_q;
               force_clr = 1'b1;
               state_d   = S_IDLE;
            end else if (tmo_q == TW'(TIMEOUT - 1)) begin
               abort   = 1'b1;
               state_d = S_IDLE;
            end else begin
               tmo_d = tmo_q + TW'(1);
            end
         end
         default: state_d = S_IDLE;
      endcase

      // A new request arriving with the servicing write's ack stays pending.
      force_d = (force_q && !force_clr) || force_i;

      // Clear first so an abort in the same cycle is still recorded.
      if (clear_i) begin
         timeout_d = 1'b0;
         err_d     = 8'h00;
      end
      if (abort) begin
         timeout_d = 1'b1;
         err_d     = (err_d == 8'hFF) ? 8'hFF : err_d + 8'h01;
      end

      cyc_d = (state_d != S_IDLE);
      we_d  = (state_d == S_WR);
      adr_d = (state_d == S_WR);
      sel_d = cyc_d ? 2'b11 : 2'b00;
      dat_d = (state_d == S_WR) ? {8'h00, sw_val_d} : 16'h0000;
   end

   always_ff @(posedge wb_clk_i) begin
      if (wb_rst_i) begin
         state_q   <= S_IDLE;
         poll_q    <= PW'(PERIOD - 1);
         tmo_q     <= '0;
         sw_val_q  <= 8'h00;
         led_q     <= 8'h00;
         force_q   <= 1'b0;
         timeout_q <= 1'b0;
         err_q     <= 8'h00;
         cyc_q     <= 1'b0;
         we_q      <= 1'b0;
         adr_q     <= 1'b0;
         sel_q     <= 2'b00;
         dat_q     <= 16'h0000;
      end else begin
         state_q   <= state_d;
         poll_q    <= poll_d;
         tmo_q     <= tmo_d;
         sw_val_q  <= sw_val_d;
         led_q     <= led_d;
         force_q   <= force_d;
         timeout_q <= timeout_d;
         err_q     <= err_d;
         cyc_q     <= cyc_d;
         we_q      <= we_d;
         adr_q     <= adr_d;
         sel_q     <= sel_d;
         dat_q     <= dat_d;
      end
   end

   assign wb_cyc_o  = cyc_q;
   assign wb_stb_o  = cyc_q;
   assign wb_we_o   = we_q;
   assign wb_adr_o  = adr_q;
   assign wb_sel_o  = sel_q;
   assign wb_dat_o  = dat_q;
   assign busy_o    = cyc_q;
   assign sw_val_o  = sw_val_q;
   assign timeout_o = timeout_q;
   assign err_cnt_o = err_q;

endmodule
`default_nettype wire

// File: tb/tb_wb_gpio_master.sv
`default_nettype none
// ============================================================================
// tb_wb_gpio_master : directed bench for wb_gpio_master with a switch/LED slave model
// Rev 1.0
// ============================================================================
module tb_wb_gpio_master;

   logic        clk = 1'b0;
   logic        rst;
   logic        adr;
   logic [15:0] dat_o;
   logic [15:0] dat_i;
   logic [1:0]  sel;
   logic        we, stb, cyc, ack;
   logic        enable, force_p, clear;
   logic [7:0]  sw_val;
   logic        busy, tmo;
   logic [7:0]  err_cnt;

   logic [7:0]  switches;
   logic [7:0]  leds;
   logic        ack_en;
   logic        spur;

   int errors = 0;
   int checks = 0;

   always #5 clk = ~clk;

   // Slave with combinational ack; LEDs latch on an acknowledged write.
   assign ack   = (cyc && stb && ack_en) || spur;
   assign dat_i = {8'h00, switches};

   always @(posedge clk) begin
      if (rst)                        leds <= 8'h00;
      else if (cyc && stb && we && ack) leds <= dat_o[7:0];
   end

   wb_gpio_master #(.PERIOD(8), .TIMEOUT(4), .DEB_COUNT(4)) dut (
      .wb_clk_i (clk),
      .wb_rst_i (rst),
      .wb_adr_o (adr),
      .wb_dat_o (dat_o),
      .wb_dat_i (dat_i),
      .wb_sel_o (sel),
      .wb_we_o  (we),
      .wb_stb_o (stb),
      .wb_cyc_o (cyc),
      .wb_ack_i (ack),
      .enable_i (enable),
      .force_i  (force_p),
      .clear_i  (clear),
      .sw_val_o (sw_val),
      .busy_o   (busy),
      .timeout_o(tmo),
      .err_cnt_o(err_cnt)
   );

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp)
      else begin
         errors++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic wait_poll();
      int n = 0;
      while (!cyc && n < 20) begin
         tick();
         n++;
      end
      check("poll_start", {31'd0, cyc}, 32'd1);
   endtask

   initial begin
      #100000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1, "watchdog");
   end

   initial begin
      rst = 1'b1; enable = 1'b1; force_p = 1'b0; clear = 1'b0;
      switches = 8'hA5; ack_en = 1'b1; spur = 1'b0;
      tick(); tick();
      rst = 1'b0;

      // Reset state and 8-cycle idle before the first read
      check("rst_cyc",  {31'd0, cyc}, 32'd0);
      check("rst_stb",  {31'd0, stb}, 32'd0);
      check("rst_dat",  {16'd0, dat_o}, 32'd0);
      check("rst_sel",  {30'd0, sel}, 32'd0);
      check("rst_sw",   {24'd0, sw_val}, 32'd0);
      check("rst_tmo",  {31'd0, tmo}, 32'd0);
      check("rst_err",  {24'd0, err_cnt}, 32'd0);
      for (int i = 0; i < 7; i++) begin
         tick();
         check("idle_cyc", {31'd0, cyc}, 32'd0);
      end
      tick();
      check("rd_cyc", {31'd0, cyc}, 32'd1);
      check("rd_stb", {31'd0, stb}, 32'd1);
      check("rd_adr", {31'd0, adr}, 32'd0);
      check("rd_we",  {31'd0, we}, 32'd0);
      check("rd_sel", {30'd0, sel}, 32'd3);

`ifdef SW_DEBOUNCE_EN
      for (int k = 0; k < 3; k++) begin
         tick();
         check("deb_no_wr", {31'd0, cyc}, 32'd0);
         wait_poll();
      end
`endif

      // New value: RD then WR back-to-back
      tick();
      check("wr_sw",   {24'd0, sw_val}, 32'hA5);
      check("wr_cyc",  {31'd0, cyc}, 32'd1);
      check("wr_adr",  {31'd0, adr}, 32'd1);
      check("wr_we",   {31'd0, we}, 32'd1);
      check("wr_dat",  {16'd0, dat_o}, 32'h00A5);
      tick();
      check("wr_done", {31'd0, cyc}, 32'd0);
      check("leds",    {24'd0, leds}, 32'hA5);

      // Unchanged value: single-cycle read, no write
      wait_poll();
      check("rd2_we", {31'd0, we}, 32'd0);
      tick();
      check("rd2_only", {31'd0, cyc}, 32'd0);

      // Spurious ack while idle is ignored
      spur = 1'b1; switches = 8'h11;
      tick();
      spur = 1'b0; switches = 8'hA5;
      check("spur_cyc", {31'd0, cyc}, 32'd0);
      check("spur_sw",  {24'd0, sw_val}, 32'hA5);

      // Timeout abort and clear
      ack_en = 1'b0;
      wait_poll();
      for (int i = 0; i < 3; i++) begin
         tick();
         check("tmo_hold", {31'd0, cyc}, 32'd1);
      end
      tick();
      check("tmo_drop", {31'd0, cyc}, 32'd0);
      check("tmo_flag", {31'd0, tmo}, 32'd1);
      check("tmo_err",  {24'd0, err_cnt}, 32'd1);
      check("tmo_sw",   {24'd0, sw_val}, 32'hA5);
      ack_en = 1'b1;
      clear = 1'b1;
      tick();
      clear = 1'b0;
      check("clr_flag", {31'd0, tmo}, 32'd0);
      check("clr_err",  {24'd0, err_cnt}, 32'd0);

      // Forced write with unchanged switches, then read-only poll
      force_p = 1'b1;
      tick();
      force_p = 1'b0;
      wait_poll();
      check("frc_rd_we", {31'd0, we}, 32'd0);
      tick();
      check("frc_wr_we",  {31'd0, we}, 32'd1);
      check("frc_wr_dat", {16'd0, dat_o}, 32'h00A5);
      tick();
      check("frc_done", {31'd0, cyc}, 32'd0);
      wait_poll();
      tick();
      check("frc_after", {31'd0, cyc}, 32'd0);

      // Reset during a write
      force_p = 1'b1;
      tick();
      force_p = 1'b0;
      wait_poll();
      tick();
      check("pre_rst_we", {31'd0, we}, 32'd1);
      rst = 1'b1;
      tick();
      rst = 1'b0;
      check("mid_rst_cyc", {31'd0, cyc}, 32'd0);
      check("mid_rst_stb", {31'd0, stb}, 32'd0);
      check("mid_rst_sw",  {24'd0, sw_val}, 32'd0);

`ifdef SW_DEBOUNCE_EN
      switches = 8'h3C;
      for (int k = 0; k < 3; k++) begin
         wait_poll();
         tick();
         check("deb3c_sw",    {24'd0, sw_val}, 32'h3C);
         check("deb3c_no_wr", {31'd0, cyc}, 32'd0);
      end
      wait_poll();
      tick();
      check("deb3c_wr_we",  {31'd0, we}, 32'd1);
      check("deb3c_wr_dat", {16'd0, dat_o}, 32'h003C);
`else
      // LED shadow returned to 0, so the same switch value is written again
      wait_poll();
      tick();
      check("post_rst_sw",  {24'd0, sw_val}, 32'hA5);
      check("post_rst_we",  {31'd0, we}, 32'd1);
      check("post_rst_dat", {16'd0, dat_o}, 32'h00A5);
`endif
      tick();
      check("final_idle", {31'd0, cyc}, 32'd0);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
`default_nettype wire
